// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the signed-magnitude multiplier sequencer.
package mul_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter must hold the value N itself, not just N-1.
    function automatic int unsigned sc_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Parallel-load down-counter holding the remaining-iteration count.
module seq_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign is_one = (count == W'(1));

endmodule

// File: rtl/mul_control_unit.sv
// Sequencer for the shift-and-add multiplier: load, sign, N add/shift iterations, done.
module mul_control_unit
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   q_lsb,
    input  logic                   op_zero,
    output logic                   load_operands,
    output logic                   clear_acc,
    output logic                   sign_xor,
    output logic                   add_b,
    output logic                   shift_eaq,
    output logic                   clear_result,
    output logic                   busy,
    output logic                   done,
    output logic [sc_width(N)-1:0] sc
);

    localparam int unsigned SC_W = sc_width(N);

    state_t    state;
    state_t    next_state;
    logic      sc_load;
    logic      sc_dec;
    logic      sc_is_one;

    seq_counter #(
        .W (SC_W)
    ) u_seq_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (sc_load),
        .dec      (sc_dec),
        .load_val (SC_W'(N)),
        .count    (sc),
        .is_one   (sc_is_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = INIT;
            INIT:    next_state = op_zero ? DONE : ADD;
            ADD:     next_state = SHIFT;
            SHIFT:   next_state = sc_is_one ? DONE : ADD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded from the current state (and inputs) so the datapath
    // acts in the same cycle; reset forces them low to abort cleanly.
    always_comb begin
        load_operands = 1'b0;
        clear_acc     = 1'b0;
        sign_xor      = 1'b0;
        add_b         = 1'b0;
        shift_eaq     = 1'b0;
        clear_result  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        sc_load       = 1'b0;
        sc_dec        = 1'b0;
        if (!reset) begin
            busy = (state != IDLE);
            unique case (state)
                IDLE:  load_operands = start;
                INIT: begin
                    if (op_zero) begin
                        clear_result = 1'b1;
                    end else begin
                        clear_acc = 1'b1;
                        sign_xor  = 1'b1;
                        sc_load   = 1'b1;
                    end
                end
                ADD:   add_b = q_lsb;
                SHIFT: begin
                    shift_eaq = 1'b1;
                    sc_dec    = 1'b1;
                end
                DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_control_unit.sv
// Scoreboard bench: sequencer driving a behavioural B/A/Q/E datapath, N=4.
module tb_mul_control_unit;

    localparam int N = 4;
    localparam int W = $clog2(N + 1);

    typedef struct {
        logic [2*N-1:0] prod;
        logic           sign;
        int             shifts;
        logic [N-1:0]   pat;
        int             cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, q_lsb, op_zero;
    logic load_operands, clear_acc, sign_xor, add_b, shift_eaq, clear_result, busy, done;
    logic [W-1:0] sc;

    logic [N-1:0] b_in, q_in, B, A, Q;
    logic         bs_in, qs_in, Bs, Qs, As, E;
    logic s_load = 0, s_clr_acc = 0, s_sign = 0, s_add = 0, s_shift = 0, s_clr_res = 0;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           load_cyc = 0;
    int           iter = 0;
    int           done_count = 0;
    logic [N-1:0] add_pat = '0;
    logic         prev_done = 0;
    logic         prev_load = 0;

    mul_control_unit #(.N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .q_lsb         (q_lsb),
        .op_zero       (op_zero),
        .load_operands (load_operands),
        .clear_acc     (clear_acc),
        .sign_xor      (sign_xor),
        .add_b         (add_b),
        .shift_eaq     (shift_eaq),
        .clear_result  (clear_result),
        .busy          (busy),
        .done          (done),
        .sc            (sc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural datapath reacting to the strobes seen in the previous half cycle.
    assign q_lsb   = Q[0];
    assign op_zero = (B == '0) || (Q == '0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (s_load) begin
                B <= b_in; Q <= q_in; Bs <= bs_in; Qs <= qs_in;
            end
            if (s_clr_acc) begin
                A <= '0; E <= 1'b0;
            end
            if (s_sign) As <= Bs ^ Qs;
            if (s_add) {E, A} <= {1'b0, A} + {1'b0, B};
            if (s_shift) {E, A, Q} <= {1'b0, E, A, Q[N-1:1]};
            if (s_clr_res) begin
                A <= '0; Q <= '0; As <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int   n_strb;
        bit   zero;
        exp_t e;
        s_load = load_operands; s_clr_acc = clear_acc; s_sign = sign_xor;
        s_add = add_b; s_shift = shift_eaq; s_clr_res = clear_result;
        n_strb = int'(load_operands) + int'(clear_acc) + int'(add_b) + int'(shift_eaq) + int'(clear_result);
        if (reset) begin
            check("rst_outputs", 32'({n_strb != 0, sign_xor, busy, done}), 32'd0);
            sb.delete();
            iter = 0; prev_done = 0; prev_load = 0;
        end else begin
            check("strobe_excl", 32'(n_strb <= 1), 32'd1);
            check("sign_xor_alone", 32'(sign_xor && !clear_acc), 32'd0);
            check("load_while_busy", 32'(load_operands && busy), 32'd0);
            check("done_not_busy", 32'(done && !busy), 32'd0);
            if (prev_done) begin
                check("idle_after_done", 32'(busy), 32'd0);
                check("restart_on_start", 32'(load_operands), 32'(start));
            end
            if (prev_load) check("busy_after_load", 32'(busy), 32'd1);
            if (load_operands) begin
                zero     = (b_in == '0) || (q_in == '0);
                e.prod   = (2*N)'(b_in) * (2*N)'(q_in);
                e.sign   = zero ? 1'b0 : (bs_in ^ qs_in);
                e.shifts = zero ? 0 : N;
                e.pat    = zero ? '0 : q_in;
                e.cycles = zero ? 2 : 2*N + 2;
                sb.push_back(e);
                load_cyc = cyc; iter = 0; add_pat = '0;
            end
            if (add_b && iter < N) add_pat[iter] = 1'b1;
            if (shift_eaq) begin
                check("sc_step", 32'(sc), 32'(N - iter));
                iter++;
            end
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", 32'({A, Q}), 32'(e.prod));
                    check("sign", 32'(As), 32'(e.sign));
                    check("e_clear", 32'(E), 32'd0);
                    check("shift_count", 32'(iter), 32'(e.shifts));
                    check("add_pattern", 32'(add_pat), 32'(e.pat));
                    check("done_latency", 32'(cyc - load_cyc), 32'(e.cycles));
                    check("sc_end", 32'(sc), 32'd0);
                end
            end
            prev_done = done;
            prev_load = load_operands;
        end
    end

    task automatic wait_done(input int target, input int limit);
        int k = 0;
        while (done_count < target && k < limit) begin
            @(posedge clk);
            k++;
        end
        check("done_timeout", 32'(done_count >= target), 32'd1);
    endtask

    task automatic run_op(input logic [N-1:0] b, input logic [N-1:0] q, input logic bs, input logic qs);
        int target;
        target = done_count + 1;
        @(posedge clk); #1;
        b_in = b; q_in = q; bs_in = bs; qs_in = qs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(target, 4*N + 10);
    endtask

    initial begin
        int  dc;
        bit  found;
        reset = 1'b1; start = 1'b0;
        b_in = '0; q_in = '0; bs_in = 1'b0; qs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_sc", 32'(sc), 32'd0);
        check("reset_busy_done", 32'({busy, done}), 32'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", 32'({load_operands, clear_acc, sign_xor, add_b,
                                     shift_eaq, clear_result, busy, done}), 32'd0);
        end

        run_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        run_op(4'b0111, 4'b1010, 1'b1, 1'b0);
        run_op(4'b0000, 4'b1011, 1'b1, 1'b1);
        run_op(4'b1001, 4'b0000, 1'b0, 1'b1);
        run_op(4'b1111, 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // start held through two complete operations
        @(posedge clk); #1;
        b_in = 4'b0110; q_in = 4'b1101; bs_in = 1'b0; qs_in = 1'b1; start = 1'b1;
        dc = done_count;
        wait_done(dc + 2, 8*N + 20);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        check("held_start_ops", 32'(done_count - dc), 32'd2);

        // abort during the second SHIFT
        @(posedge clk); #1;
        b_in = 4'b0110; q_in = 4'b0111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (shift_eaq && iter == 1) found = 1;
        end
        check("reach_shift2", 32'(found), 32'd1);
        reset = 1'b1;
        dc = done_count;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_sc", 32'(sc), 32'd0);
        check("abort_outputs", 32'({load_operands, clear_acc, sign_xor, add_b,
                                    shift_eaq, clear_result, busy, done}), 32'd0);
        repeat (30) @(posedge clk);
        check("no_done_after_abort", 32'(done_count), 32'(dc));

        run_op(4'b0011, 4'b0101, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
